lives_manager: RTL and testbench
================================

# lives_manager

Multi-player successor to the single-player lives counter. It tracks a saturating lives count per player and adds a per-player life-cycle state machine: respawn delay, post-respawn invulnerability, game over and new-game restart. Timers count frame ticks. It sits between the collision/score logic (die, bonus) and the ship renderer and HUD (alive, invuln, lives, game_over).

## Interface
- NUM_PLAYERS, 2: number of independent player channels (>=1).
- NUM_LIVES, 3: lives loaded at reset and at new game (1..MAX_NUM_LIVES).
- MAX_NUM_LIVES, 8: saturation ceiling for lives.
- RESPAWN_TICKS, 60: ticks spent in RESPAWN after a death (>=1).
- INVULN_TICKS, 120: ticks spent in INVULN after respawn (0 = skip INVULN).
- Derived: LW = $clog2(MAX_NUM_LIVES+1). TW = $clog2(max(RESPAWN_TICKS,INVULN_TICKS)+1).

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  single-cycle frame strobe; not edge-detected.
- new_game  input  1  level; its rising edge restarts all channels.
- die  input  NUM_PLAYERS  level per player; rising edge = one death.
- bonus  input  NUM_PLAYERS  level per player; rising edge = one extra life.
- lives  output  NUM_PLAYERS*LW  packed counts; player p at [p*LW +: LW].
- alive  output  NUM_PLAYERS  ship present (ALIVE or INVULN).
- invuln  output  NUM_PLAYERS  state is INVULN.
- game_over  output  NUM_PLAYERS  state is OUT.
- all_over  output  1  AND of game_over.

## Operation
- Edge detect: one delay register per die, bonus and new_game bit. These registers reset to 1, so an input already held high across reset produces no event. Event = input & ~delayed.
- Per-player states: ALIVE, RESPAWN, INVULN, OUT. Each player has a TW-bit down-timer.
- Reset: every player goes to ALIVE with lives=NUM_LIVES and timer=0. Outputs at reset: alive=all 1, invuln=0, game_over=0, all_over=0.
- new_game event: applied to all players, same result as reset. It has priority over every die, bonus and tick in that cycle.
- ALIVE + die event:
  - next = lives-1 (+1 if a bonus event occurs in the same cycle, saturating at MAX_NUM_LIVES).
  - If next==0, go to OUT.
  - Otherwise go to RESPAWN with timer=RESPAWN_TICKS. A tick in that same cycle is not counted.
- RESPAWN and INVULN:
  - die events are ignored.
  - On each tick the timer decrements.
  - A tick with timer==1 in RESPAWN goes to INVULN with timer=INVULN_TICKS, or straight to ALIVE if INVULN_TICKS==0.
  - A tick with timer==1 in INVULN goes to ALIVE.
- bonus event in ALIVE, RESPAWN or INVULN: lives+1, saturating at MAX_NUM_LIVES, with no state change.
- OUT: terminal until reset or new_game. die and bonus are ignored; lives holds 0.
- Lives never underflow below 0 and never exceed MAX_NUM_LIVES.
- Channels are fully independent. Simultaneous events on different players are all applied in the same cycle.

## Timing
- All state, lives and timer registers use async reset.
- alive, invuln and game_over decode directly from registered state. all_over is a combinational AND of the game_over bits.
- Latency is 1 cycle: an event detected at rising edge n is reflected on the outputs immediately after edge n.
- A die/bonus input held high counts once. It must return low for at least 1 cycle before re-arming.
- RESPAWN lasts exactly RESPAWN_TICKS ticks. INVULN lasts exactly INVULN_TICKS ticks.
- Reset asserted mid-respawn or mid-invuln immediately forces the reset values. No pending timer or event survives.

## Test plan
- Reset with die[0] held high, then release -> lives[0]=3, alive=2'b11, no decrement.
- die[0] edge, RESPAWN_TICKS=4, INVULN_TICKS=2:
  - -> lives[0]=2 and alive[0]=0 next cycle.
  - -> after 4 ticks invuln[0]=1.
  - -> after 2 more ticks alive[0]=1 and invuln[0]=0.
  - -> die pulses during RESPAWN/INVULN leave lives[0]=2.
- Three separated deaths on player 1 -> lives[1]=0, game_over[1]=1, bonus ignored, player 0 unaffected (all_over=0).
- Six bonus edges on player 0 from 3 -> lives[0]=8 (saturated). die+bonus in the same cycle at lives=1 -> lives=1, state RESPAWN.
- Both players OUT -> all_over=1. new_game edge simultaneous with die -> lives=3/3, alive=2'b11, all_over=0.
- Reset asserted mid-RESPAWN -> immediately lives=3, alive=1. The next tick causes no transition.

Source files
------------

// File: rtl/lives_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lives_manager
// Purpose  : Per-player saturating lives counters with a respawn /
//            invulnerability / game-over life-cycle driven by frame ticks.
// Revision : 1.0 - initial release
// ============================================================================
module lives_manager #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_LIVES     = 3,
    parameter int MAX_NUM_LIVES = 8,
    parameter int RESPAWN_TICKS = 60,
    parameter int INVULN_TICKS  = 120,
    localparam int LW   = $clog2(MAX_NUM_LIVES + 1),
    localparam int TMAX = (RESPAWN_TICKS > INVULN_TICKS) ? RESPAWN_TICKS : INVULN_TICKS,
    localparam int TW   = $clog2(TMAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      new_game,
    input  logic [NUM_PLAYERS-1:0]    die,
    input  logic [NUM_PLAYERS-1:0]    bonus,
    output logic [NUM_PLAYERS*LW-1:0] lives,
    output logic [NUM_PLAYERS-1:0]    alive,
    output logic [NUM_PLAYERS-1:0]    invuln,
    output logic [NUM_PLAYERS-1:0]    game_over,
    output logic                      all_over
);

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_RESPAWN = 2'd1,
        ST_INVULN  = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    localparam logic [LW-1:0] LIVES_INIT   = LW'(NUM_LIVES);
    localparam logic [LW-1:0] LIVES_MAX    = LW'(MAX_NUM_LIVES);
    localparam logic [TW-1:0] RESPAWN_LOAD = TW'(RESPAWN_TICKS);
    localparam logic [TW-1:0] INVULN_LOAD  = TW'(INVULN_TICKS);

    logic [NUM_PLAYERS-1:0] die_dly_q;
    logic [NUM_PLAYERS-1:0] bonus_dly_q;
    logic                   new_game_dly_q;
    logic [NUM_PLAYERS-1:0] die_ev;
    logic [NUM_PLAYERS-1:0] bonus_ev;
    logic                   new_game_ev;

    // Delay registers come out of reset high so a level held across reset is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            die_dly_q      <= '1;
            bonus_dly_q    <= '1;
            new_game_dly_q <= 1'b1;
        end else begin
            die_dly_q      <= die;
            bonus_dly_q    <= bonus;
            new_game_dly_q <= new_game;
        end
    end

    assign die_ev      = die & ~die_dly_q;
    assign bonus_ev    = bonus & ~bonus_dly_q;
    assign new_game_ev = new_game & ~new_game_dly_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        state_t          state_q;
        logic [LW-1:0]   lives_q;
        logic [LW-1:0]   lives_inc;
        logic [TW-1:0]   timer_q;
        logic            timer_last;

        assign lives_inc  = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + LW'(1);
        assign timer_last = (timer_q == TW'(1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_ALIVE;
                lives_q <= LIVES_INIT;
                timer_q <= '0;
            end else if (new_game_ev) begin
                state_q <= ST_ALIVE;
                lives_q <= LIVES_INIT;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_ALIVE: begin
                        // A bonus in the death cycle cancels the decrement.
                        if (die_ev[p]) begin
                            if (!bonus_ev[p] && lives_q == LW'(1)) begin
                                state_q <= ST_OUT;
                                lives_q <= '0;
                            end else begin
                                state_q <= ST_RESPAWN;
                                timer_q <= RESPAWN_LOAD;
                                if (!bonus_ev[p]) begin
                                    lives_q <= lives_q - LW'(1);
                                end
                            end
                        end else if (bonus_ev[p]) begin
                            lives_q <= lives_inc;
                        end
                    end
                    ST_RESPAWN, ST_INVULN: begin
                        if (bonus_ev[p]) begin
                            lives_q <= lives_inc;
                        end
                        if (tick) begin
                            if (!timer_last) begin
                                timer_q <= timer_q - TW'(1);
                            end else if (state_q == ST_RESPAWN && INVULN_TICKS != 0) begin
                                state_q <= ST_INVULN;
                                timer_q <= INVULN_LOAD;
                            end else begin
                                state_q <= ST_ALIVE;
                                timer_q <= '0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign lives[p*LW +: LW] = lives_q;
        assign alive[p]          = (state_q == ST_ALIVE) || (state_q == ST_INVULN);
        assign invuln[p]         = (state_q == ST_INVULN);
        assign game_over[p]      = (state_q == ST_OUT);
    end

    assign all_over = &game_over;

endmodule
`default_nettype wire

// File: tb/tb_lives_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lives_manager
// Purpose  : Scoreboard bench for lives_manager with a small behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lives_manager;

    localparam int NP = 2;
    localparam int NL = 3;
    localparam int MX = 8;
    localparam int RT = 4;
    localparam int IT = 2;
    localparam int S_ALIVE = 0;
    localparam int S_RESP  = 1;
    localparam int S_INV   = 2;
    localparam int S_OUT   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       new_game = 1'b0;
    logic [1:0] die = 2'b01;
    logic [1:0] bonus = 2'b00;
    logic [7:0] lives;
    logic [1:0] alive;
    logic [1:0] invuln;
    logic [1:0] game_over;
    logic       all_over;
    logic [14:0] obs;

    lives_manager #(
        .NUM_PLAYERS  (NP),
        .NUM_LIVES    (NL),
        .MAX_NUM_LIVES(MX),
        .RESPAWN_TICKS(RT),
        .INVULN_TICKS (IT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .new_game (new_game),
        .die      (die),
        .bonus    (bonus),
        .lives    (lives),
        .alive    (alive),
        .invuln   (invuln),
        .game_over(game_over),
        .all_over (all_over)
    );

    always #5 clk = ~clk;

    assign obs = {lives, alive, invuln, game_over, all_over};

    typedef struct packed {
        logic       tk;
        logic       ng;
        logic [1:0] d;
        logic [1:0] b;
    } stim_t;

    stim_t       stim_q[$];
    logic [14:0] sb[$];
    logic [14:0] want;
    int          vectors = 0;
    int          miscompares = 0;

    int         m_st[2];
    int         m_lives[2];
    int         m_tmr[2];
    logic       m_ng_d;
    logic [1:0] m_die_d;
    logic [1:0] m_bon_d;

    task automatic model_players_init();
        for (int p = 0; p < NP; p++) begin
            m_st[p]    = S_ALIVE;
            m_lives[p] = NL;
            m_tmr[p]   = 0;
        end
    endtask

    task automatic model_reset();
        model_players_init();
        m_ng_d  = 1'b1;
        m_die_d = 2'b11;
        m_bon_d = 2'b11;
    endtask

    task automatic model_step(input stim_t s);
        logic       ng_ev;
        logic [1:0] de;
        logic [1:0] be;
        ng_ev   = s.ng & ~m_ng_d;
        de      = s.d & ~m_die_d;
        be      = s.b & ~m_bon_d;
        m_ng_d  = s.ng;
        m_die_d = s.d;
        m_bon_d = s.b;
        if (ng_ev) begin
            model_players_init();
            return;
        end
        for (int p = 0; p < NP; p++) begin
            case (m_st[p])
                S_ALIVE: begin
                    if (de[p]) begin
                        m_lives[p] = m_lives[p] - 1 + int'(be[p]);
                        if (m_lives[p] > MX) m_lives[p] = MX;
                        if (m_lives[p] == 0) begin
                            m_st[p] = S_OUT;
                        end else begin
                            m_st[p]  = S_RESP;
                            m_tmr[p] = RT;
                        end
                    end else if (be[p]) begin
                        m_lives[p] = (m_lives[p] < MX) ? m_lives[p] + 1 : MX;
                    end
                end
                S_RESP, S_INV: begin
                    if (be[p]) m_lives[p] = (m_lives[p] < MX) ? m_lives[p] + 1 : MX;
                    if (s.tk) begin
                        m_tmr[p] = m_tmr[p] - 1;
                        if (m_tmr[p] == 0) begin
                            if (m_st[p] == S_RESP && IT > 0) begin
                                m_st[p]  = S_INV;
                                m_tmr[p] = IT;
                            end else begin
                                m_st[p] = S_ALIVE;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    function automatic logic [14:0] model_out();
        logic [1:0] al;
        logic [1:0] inv;
        logic [1:0] go;
        for (int p = 0; p < NP; p++) begin
            al[p]  = (m_st[p] == S_ALIVE) || (m_st[p] == S_INV);
            inv[p] = (m_st[p] == S_INV);
            go[p]  = (m_st[p] == S_OUT);
        end
        return {4'(m_lives[1]), 4'(m_lives[0]), al, inv, go, &go};
    endfunction

    task automatic add(input logic tk, input logic ng, input logic [1:0] d, input logic [1:0] b);
        stim_q.push_back({tk, ng, d, b});
    endtask

    task automatic add_death(input logic [1:0] m);
        add(1'b0, 1'b0, m, 2'b00);
        repeat (RT + IT) add(1'b1, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic drive(input stim_t s);
        tick     = s.tk;
        new_game = s.ng;
        die      = s.d;
        bonus    = s.b;
        model_step(s);
        sb.push_back(model_out());
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== {8'h33, 2'b11, 2'b00, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", obs, {8'h33, 2'b11, 2'b00, 2'b00, 1'b0});
        end
        model_reset();
        reset = 1'b0;
        add(1'b0, 1'b0, 2'b01, 2'b00);
        add(1'b0, 1'b0, 2'b00, 2'b00);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_held_die: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (lives[3:0] !== 4'd3) begin
            miscompares++;
            $display("FAIL reset_no_decrement: lives0 got %0d expected 3", lives[3:0]);
        end
    endtask

    task automatic test_respawn();
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0: add(1'b0, 1'b0, 2'b01, 2'b00);
                1: begin
                    add(1'b1, 1'b0, 2'b00, 2'b00);
                    add(1'b1, 1'b0, 2'b01, 2'b00);
                    add(1'b1, 1'b0, 2'b00, 2'b00);
                    add(1'b1, 1'b0, 2'b00, 2'b00);
                end
                default: begin
                    add(1'b0, 1'b0, 2'b01, 2'b00);
                    add(1'b1, 1'b0, 2'b00, 2'b00);
                    add(1'b1, 1'b0, 2'b00, 2'b00);
                end
            endcase
            while (stim_q.size() > 0) begin
                drive(stim_q.pop_front());
                @(posedge clk);
                #1;
                want = sb.pop_front();
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL respawn_ph%0d: got %h expected %h", ph, obs, want);
                end
            end
            vectors++;
            case (ph)
                0: if (lives[3:0] !== 4'd2 || alive[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL respawn_death: lives0=%0d alive0=%b expected 2/0", lives[3:0], alive[0]);
                end
                1: if (lives[3:0] !== 4'd2 || invuln[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL respawn_to_invuln: lives0=%0d invuln0=%b expected 2/1", lives[3:0], invuln[0]);
                end
                default: if (lives[3:0] !== 4'd2 || alive[0] !== 1'b1 || invuln[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL invuln_to_alive: lives0=%0d alive0=%b invuln0=%b expected 2/1/0",
                             lives[3:0], alive[0], invuln[0]);
                end
            endcase
        end
    endtask

    task automatic test_game_over();
        repeat (3) add_death(2'b10);
        add(1'b0, 1'b0, 2'b00, 2'b10);
        add(1'b0, 1'b0, 2'b00, 2'b00);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL game_over_seq: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (lives !== 8'h02 || game_over !== 2'b10 || alive !== 2'b01 || all_over !== 1'b0) begin
            miscompares++;
            $display("FAIL game_over_p1: lives=%h go=%b alive=%b all=%b expected 02/10/01/0",
                     lives, game_over, alive, all_over);
        end
    endtask

    task automatic test_bonus_sat();
        add(1'b0, 1'b1, 2'b00, 2'b00);
        add(1'b0, 1'b0, 2'b00, 2'b00);
        repeat (6) begin
            add(1'b0, 1'b0, 2'b00, 2'b01);
            add(1'b0, 1'b0, 2'b00, 2'b00);
        end
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL bonus_seq: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (lives[3:0] !== 4'd8) begin
            miscompares++;
            $display("FAIL bonus_saturate: lives0 got %0d expected 8", lives[3:0]);
        end
        add_death(2'b10);
        add_death(2'b10);
        add(1'b0, 1'b0, 2'b10, 2'b10);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL die_bonus_seq: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (lives[7:4] !== 4'd1 || alive[1] !== 1'b0 || game_over[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL die_bonus_same_cycle: lives1=%0d alive1=%b go1=%b expected 1/0/0",
                     lives[7:4], alive[1], game_over[1]);
        end
    endtask

    task automatic test_all_over();
        add(1'b0, 1'b1, 2'b00, 2'b00);
        add(1'b0, 1'b0, 2'b00, 2'b00);
        repeat (3) add_death(2'b11);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL all_over_seq: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (all_over !== 1'b1 || lives !== 8'h00) begin
            miscompares++;
            $display("FAIL all_over_set: all_over=%b lives=%h expected 1/00", all_over, lives);
        end
        add(1'b0, 1'b1, 2'b11, 2'b00);
        add(1'b0, 1'b0, 2'b00, 2'b00);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL new_game_seq: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (lives !== 8'h33 || alive !== 2'b11 || all_over !== 1'b0) begin
            miscompares++;
            $display("FAIL new_game_priority: lives=%h alive=%b all=%b expected 33/11/0", lives, alive, all_over);
        end
    endtask

    task automatic test_reset_mid();
        add(1'b0, 1'b0, 2'b01, 2'b00);
        add(1'b1, 1'b0, 2'b00, 2'b00);
        add(1'b1, 1'b0, 2'b00, 2'b00);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_mid_pre: got %h expected %h", obs, want);
            end
        end
        reset = 1'b1;
        #2;
        vectors++;
        if (lives !== 8'h33 || alive !== 2'b11 || invuln !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_async: lives=%h alive=%b invuln=%b expected 33/11/00", lives, alive, invuln);
        end
        model_reset();
        reset = 1'b0;
        add(1'b1, 1'b0, 2'b00, 2'b00);
        add(1'b1, 1'b0, 2'b00, 2'b00);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk);
            #1;
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_mid_post: got %h expected %h", obs, want);
            end
        end
        vectors++;
        if (alive !== 2'b11 || invuln !== 2'b00 || lives !== 8'h33) begin
            miscompares++;
            $display("FAIL reset_mid_no_transition: alive=%b invuln=%b lives=%h expected 11/00/33",
                     alive, invuln, lives);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_respawn();
        test_game_over();
        test_bonus_sat();
        test_all_over();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
